// File: rtl/fifo_burst_pkg.sv
// ----------------------------------------------------------------------------
// fifo_burst_pkg
// Shared types and constants for the FIFO burst reader.
//   state_e     : reader FSM states (IDLE, BURST)
//   BURST_CNT_W : width of the optional completed-burst statistics counter
// ----------------------------------------------------------------------------
package fifo_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int BURST_CNT_W = 32;

endpackage

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// ----------------------------------------------------------------------------
// stream_out_reg
// Single-entry valid/ready output register with an explicit load port.
// The producer decides when to load (it must only do so when the register is
// empty or being drained this cycle); this block just holds the payload.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture din and raise valid
//   din  [W]     : payload to capture
//   ready        : downstream ready; drops valid when no new load arrives
//   dout [W]     : registered payload (held while stalled)
//   valid        : registered valid
// ----------------------------------------------------------------------------
module stream_out_reg #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid
);

    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end else if (ready) begin
            // Drained with nothing new behind it: payload is left as-is,
            // only valid falls.
            valid_q <= 1'b0;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader
// Read-side burst packetizer behind a show-ahead FIFO. Waits in IDLE until a
// full burst of BURSTLEN words is available (or flush asks for whatever is
// left), then streams exactly that many words out with sop/eop framing.
// Ports:
//   clk, reset_n        : FIFO read clock, asynchronous active-low reset
//   fifo_data/empty/used: show-ahead head word, empty flag, fill level
//   fifo_req            : combinational FIFO read strobe
//   flush               : level request for a short burst (sampled in IDLE)
//   out_data/valid/ready/sop/eop : registered packet stream
//   burst_cnt           : completed-burst counter, only present when the
//                         macro FIFO_BURST_READER_STAT_EN is defined
// ----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int BURSTLEN = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [WIDTH-1:0]             fifo_data,
    input  logic                         fifo_empty,
    input  logic [$clog2(DEPTH+1)-1:0]   fifo_used,
    output logic                         fifo_req,
    input  logic                         flush,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sop,
`ifdef FIFO_BURST_READER_STAT_EN
    output logic [BURST_CNT_W-1:0]       burst_cnt,
`endif
    output logic                         out_eop
);

    localparam int             UW   = $clog2(DEPTH + 1);
    localparam logic [UW-1:0]  BL_U = UW'(BURSTLEN);

    state_e          state_q, state_d;
    logic [UW-1:0]   rem_q, rem_d;
    logic            first_q, first_d;   // next load is the burst's first word
    logic            load;
    logic            last_word;

    // "<= 1" rather than "== 1" so an inconsistent empty/used pair that loads
    // rem with 0 still terminates the burst instead of wrapping the counter.
    assign last_word = (rem_q <= UW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        first_d = first_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                // Full burst takes priority over a pending flush.
                if (fifo_used >= BL_U) begin
                    state_d = BURST;
                    rem_d   = BL_U;
                    first_d = 1'b1;
                end else if (flush && !fifo_empty) begin
                    state_d = BURST;
                    rem_d   = fifo_used;
                    first_d = 1'b1;
                end
            end
            BURST: begin
                // Read only when the output register is free or draining now;
                // an empty FIFO simply stalls the burst.
                load = !fifo_empty && (!out_valid || out_ready);
                if (load) begin
                    first_d = 1'b0;
                    if (last_word) begin
                        rem_d   = '0;
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - UW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_req = load;

    stream_out_reg #(
        .W (WIDTH + 2)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .din     ({fifo_data, first_q, last_word}),
        .ready   (out_ready),
        .dout    ({out_data, out_sop, out_eop}),
        .valid   (out_valid)
    );

`ifdef FIFO_BURST_READER_STAT_EN
    logic [BURST_CNT_W-1:0] burst_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_q <= '0;
        end else if (out_valid && out_ready && out_eop) begin
            burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
        end
    end

    assign burst_cnt = burst_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Self-checking bench: a queue models the upstream show-ahead FIFO, and the
// expected output stream is built at packet level (words in FIFO order, cut
// into bursts of BURSTLEN or a flush remainder, sop on first, eop on last).
// ----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int BURSTLEN = 4;
    localparam int UW       = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [WIDTH-1:0]  fifo_data;
    logic              fifo_empty;
    logic [UW-1:0]     fifo_used;
    logic              fifo_req;
    logic              flush = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_sop;
    logic              out_eop;
`ifdef FIFO_BURST_READER_STAT_EN
    logic [31:0]       burst_cnt;
`endif

    fifo_burst_reader #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .BURSTLEN (BURSTLEN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_used  (fifo_used),
        .fifo_req   (fifo_req),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
`ifdef FIFO_BURST_READER_STAT_EN
        .burst_cnt  (burst_cnt),
`endif
        .out_eop    (out_eop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             sop;
        logic             eop;
    } beat_t;

    logic [WIDTH-1:0] fq[$];      // upstream FIFO contents
    logic [WIDTH-1:0] pend[$];    // pushed words not yet assigned to a packet
    beat_t            exp_q[$];   // expected output beats in order
    bit               req_log[$];
    bit               val_log[$];

    int               n_tests = 0;
    int               n_fail  = 0;
    int               hs_cnt  = 0;
    int               ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
    bit               tog = 1'b1;
    bit               prev_stall = 1'b0;
    logic [WIDTH+1:0] prev_beat = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
        fifo_used  = UW'(fq.size());
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        pend.push_back(w);
    endtask

    task automatic expect_burst(input int len);
        beat_t e;
        for (int i = 0; i < len; i++) begin
            e.d   = pend.pop_front();
            e.sop = (i == 0);
            e.eop = (i == len - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: entered at a falling edge with inputs applied.
    task automatic tick();
        beat_t e;
        bit    req_s;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = tog; tog = ~tog; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_payload", 64'({out_data, out_sop, out_eop}), 64'(prev_beat));
        end
        if (fifo_req) begin
            check("req_legal", 64'({fifo_empty, out_valid & ~out_ready}), 64'(0));
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            $display("[TB] beat data=0x%02h sop=%0b eop=%0b", out_data, out_sop, out_eop);
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'({out_data, out_sop, out_eop}), 64'(e));
            end
        end
        prev_stall = out_valid & ~out_ready;
        prev_beat  = {out_data, out_sop, out_eop};
        req_log.push_back(fifo_req);
        val_log.push_back(out_valid);
        req_s = fifo_req;
        @(posedge clk);
        if (req_s && fq.size() != 0) void'(fq.pop_front());
        @(negedge clk);
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bit done;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        done = (exp_q.size() == 0) && !out_valid;
        check("drain_done", 64'(done), 64'(1));
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fq.delete();
        pend.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        drive_fifo();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int r;
        int k;
        int pushed;

        drive_fifo();
        @(negedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_sop",   64'(out_sop),   64'(0));
        check("rst_eop",   64'(out_eop),   64'(0));
        check("rst_data",  64'(out_data),  64'(0));
        check("rst_req",   64'(fifo_req),  64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();

        // Full burst with latency check.
        ready_mode = 0;
        for (int i = 0; i < 4; i++) push_word(WIDTH'(32'h11 + i));
        expect_burst(4);
        drive_fifo();
        base = req_log.size();
        drain(40);
        check("lat_req_n",  64'(req_log[base]), 64'(0));
        for (int i = 1; i <= 4; i++) check("lat_req_burst", 64'(req_log[base + i]), 64'(1));
        check("lat_req_end", 64'(req_log[base + 5]), 64'(0));
        check("lat_val_n1",  64'(val_log[base + 1]), 64'(0));
        check("lat_val_n2",  64'(val_log[base + 2]), 64'(1));

        // Short flush burst.
        for (int i = 0; i < 3; i++) push_word(WIDTH'(32'hA0 + i));
        drive_fifo();
        flush = 1'b1;
        expect_burst(3);
        drain(40);

        // Flush with nothing in the FIFO produces nothing.
        base = req_log.size();
        repeat (6) tick();
        for (int i = 0; i < 6; i++) begin
            check("flush_empty_valid", 64'(val_log[base + i]), 64'(0));
            check("flush_empty_req",   64'(req_log[base + i]), 64'(0));
        end
        flush = 1'b0;

        // Backpressure: ready toggles every cycle over two bursts.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom));
        expect_burst(4);
        expect_burst(4);
        drive_fifo();
        drain(100);

        // Priority: five words with flush high gives 4 then 1.
        ready_mode = 0;
        for (int i = 0; i < 5; i++) push_word(WIDTH'($urandom));
        flush = 1'b1;
        expect_burst(4);
        expect_burst(1);
        drive_fifo();
        drain(60);
        flush = 1'b0;

        // Randomized rounds: trickled pushes, random ready, then a flush tail.
        ready_mode = 2;
        for (int round = 0; round < 6; round++) begin
            k = BURSTLEN * int'($urandom_range(2, 5));
            pushed = 0;
            n = 0;
            while (pushed < k && n < 2000) begin
                if (fq.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                    push_word(WIDTH'($urandom));
                    pushed++;
                    while (pend.size() >= BURSTLEN) expect_burst(BURSTLEN);
                    drive_fifo();
                end
                tick();
                n++;
            end
            drain(400);
            r = int'($urandom_range(0, BURSTLEN - 1));
            for (int i = 0; i < r; i++) push_word(WIDTH'($urandom));
            drive_fifo();
            repeat (4) tick();
            flush = 1'b1;
            if (r > 0) expect_burst(r);
            drain(200);
            flush = 1'b0;
        end

        // Reset in the middle of a burst.
        ready_mode = 0;
        for (int i = 0; i < 4; i++) push_word(WIDTH'(32'h30 + i));
        expect_burst(4);
        drive_fifo();
        hs_cnt = 0;
        n = 0;
        while (hs_cnt < 2 && n < 20) begin
            tick();
            n++;
        end
        check("mid_two_beats", 64'(hs_cnt), 64'(2));
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_sop",   64'(out_sop),   64'(0));
        check("mid_rst_eop",   64'(out_eop),   64'(0));
        check("mid_rst_data",  64'(out_data),  64'(0));
        check("mid_rst_req",   64'(fifo_req),  64'(0));
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) push_word(WIDTH'(32'h50 + i));
        expect_burst(4);
        drive_fifo();
        drain(40);

`ifdef FIFO_BURST_READER_STAT_EN
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) push_word(WIDTH'($urandom));
            expect_burst(4);
            drive_fifo();
            drain(40);
        end
        check("stat_three", 64'(burst_cnt), 64'(3));
        force dut.burst_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.burst_cnt_q;
        @(negedge clk);
        check("stat_preload", 64'(burst_cnt), 64'(32'hFFFF_FFFF));
        for (int i = 0; i < 4; i++) push_word(WIDTH'($urandom));
        expect_burst(4);
        drive_fifo();
        drain(40);
        check("stat_wrap", 64'(burst_cnt), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side burst packetizer placed directly downstream of the team's asynchronous FIFO, in the read clock domain. Monitors the FIFO's show-ahead read port and fill level. Drains whole bursts of BURSTLEN words, or a short burst on flush, into a registered valid/ready stream framed with start- and end-of-packet flags. Feeds packet-oriented consumers such as DMA writers and link framers.

## Interface
- WIDTH, 8: data width (>0)
- DEPTH, 8: depth of the upstream FIFO (power of two, >1); sets the width of fifo_used
- BURSTLEN, 4: words per full burst (1..DEPTH)
- clk  in  1  clock (the FIFO read clock)
- reset_n  in  1  reset; one clock, asynchronous, active-low
- fifo_data  in  WIDTH  show-ahead FIFO head word
- fifo_empty  in  1  FIFO empty flag
- fifo_used  in  $clog2(DEPTH+1)  FIFO read-side fill level
- fifo_req  out  1  FIFO read strobe (combinational)
- flush  in  1  request a short burst of the remaining words
- out_data  out  WIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_sop  out  1  first word of burst
- out_eop  out  1  last word of burst

## Operation
- States: IDLE and BURST; state type is an enum.
- Remaining-word counter `rem` is $clog2(DEPTH+1) bits wide.
- **IDLE to BURST, full burst:** if fifo_used >= BURSTLEN, set `rem` = BURSTLEN.
- **IDLE to BURST, short burst:** else if flush=1 and fifo_empty=0, set `rem` = fifo_used.
- **Priority:** the full-burst condition wins over flush.
- **Flush handling:** flush is level-sampled only in IDLE. It is ignored during BURST.
- **Load condition:** in BURST, `load` = ~fifo_empty & (~out_valid | out_ready).
- fifo_req = `load`; it is never asserted in IDLE.
- **On each load:**
  - out_data ← fifo_data
  - out_valid ← 1
  - out_sop ← (first word of burst)
  - out_eop ← (`rem` == 1)
  - `rem` decrements
- **BURST to IDLE:** on the load where `rem` == 1.
- **Output register without load:** if out_ready=1, out_valid ← 0. Otherwise data and flags hold.
- **Stream rules:**
  - out_data, out_sop and out_eop are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- **fifo_empty=1 in BURST:** only possible defensively. The block stalls, with no fifo_req, and does not abort the burst.
- **Arithmetic:** all unsigned; `rem` never underflows.

## Timing
- Reset values: fifo_req=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, state=IDLE, `rem`=0.
- Latency: fifo_used reaches BURSTLEN in cycle n. Then BURST starts in n+1, fifo_req=1 in n+1, and out_valid=1 in n+2.
- Throughput: one word per cycle while out_ready=1. The FIFO is read in the same cycle the output register is drained.
- Re-arm: IDLE is entered the cycle after the last fifo_req. fifo_used is re-evaluated there, so there is one bubble cycle between back-to-back bursts.
- BURSTLEN=1: every word has out_sop=out_eop=1.
- Reset mid-burst: immediate return to reset values. Words already read from the FIFO are lost; a partial burst is never completed after reset.

## Configuration
- Macro: FIFO_BURST_READER_STAT_EN.
- **Defined:** adds port `burst_cnt  out  32`. It resets to 0 and increments on every out_valid & out_ready & out_eop handshake, wrapping from 2^32-1 to 0.
- **Undefined:** the port and its counter do not exist. All other behaviour is identical.

## Structure
- Package fifo_burst_pkg holds:
  - the state enum typedef (IDLE, BURST)
  - the burst-counter width constant (32)
- One sub-module: stream_out_reg, the WIDTH+2-bit valid/ready output register with a load port. fifo_burst_reader holds the FSM and counters.

## Test plan
- **Full burst:** fill with 4 words 0x11..0x14, BURSTLEN=4, out_ready=1. Expect fifo_req pulses for 4 cycles, then words 0x11..0x14 with sop on 0x11 and eop on 0x14, first valid 2 cycles after fifo_used=4.
- **Short flush:** 3 words 0xA0..0xA2 and flush=1 in IDLE. Expect a 3-word burst with eop on 0xA2. With 0 words, flush=1 gives no output.
- **Backpressure:** toggle out_ready 1/0 every cycle during an 8-word stream (2 bursts). Expect data and flags held while stalled, no duplicates or losses, fifo_req only when the register is free.
- **Priority:** fifo_used=5 with flush=1 and BURSTLEN=4. Expect a full 4-word burst, then a 1-word flush burst if flush is still high.
- **Reset mid-burst:** reset_n=0 after the second word handshake. Expect all outputs 0 immediately. After release with 4 new words, a new burst starts with sop.
- **STAT_EN:** with the macro defined, 3 bursts give burst_cnt=3. Preload to 0xFFFFFFFF via a forced value, then one burst gives 0.
